// File: rtl/compare_arbiter_if.sv
// compare_arbiter_if
//   Bundles the two requester handshakes, the shared response bus and the
//   shared comparator connection used by compare_arbiter.
//
//   Handshake rule: a request transfers in the cycle where reqN_valid and
//   reqN_ready are both high. The arbiter raises reqN_ready only while it is
//   idle, only for the requester it picks, and combinationally from the
//   valids. A requester may drop valid before that cycle; nothing changes.
//   respN_valid is a one-cycle pulse that qualifies resp_result/resp_err.
//
//   master : requesters and comparator (drive requests and cmp_result)
//   slave  : the arbiter (drives ready, responses and comparator operands)
interface compare_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_number0;
  logic [15:0] req0_number1;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_number0;
  logic [15:0] req1_number1;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [2:0]  resp_result;
  logic        resp_err;
  logic [15:0] cmp_number0;
  logic [15:0] cmp_number1;
  logic [2:0]  cmp_result;

  modport master (
    output req0_valid, req0_number0, req0_number1,
    output req1_valid, req1_number0, req1_number1,
    output cmp_result,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_result, resp_err,
    input  cmp_number0, cmp_number1
  );

  modport slave (
    input  req0_valid, req0_number0, req0_number1,
    input  req1_valid, req1_number0, req1_number1,
    input  cmp_result,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_err,
    output cmp_number0, cmp_number1
  );
endinterface

// File: rtl/compare_arbiter.sv
// compare_arbiter
//   Shares one external magnitude comparator between two requesters.
//   Round-robin arbitration picks one operand pair at a time, drives it to
//   the comparator, waits CMP_LATENCY cycles, samples the comparator result
//   and returns it to the requester that was granted. Only one request is in
//   flight at a time.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   bus        : compare_arbiter_if.slave (requests, responses, comparator)
//   busy       : high whenever the FSM is not IDLE
//   state_dbg  : current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Parameter
//   CMP_LATENCY : comparator latency in cycles, legal range 1..4
module compare_arbiter #(
  parameter int CMP_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  compare_arbiter_if.slave    bus,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        ptr;        // preferred requester when both are valid
  logic        gnt_id;     // requester owning the in-flight request
  logic [2:0]  cnt;
  logic [15:0] num0_q;
  logic [15:0] num1_q;
  logic [2:0]  result_q;
  logic        err_q;
  logic        resp0_q;
  logic        resp1_q;
  logic        grant0;
  logic        grant1;

  function automatic logic is_legal(input logic [2:0] r);
    return (r == 3'b100) || (r == 3'b010) || (r == 3'b001);
  endfunction

  // A lone valid requester wins regardless of the pointer; the pointer only
  // breaks ties. Gating with reset keeps ready low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt_id   <= 1'b0;
      cnt      <= 3'd0;
      num0_q   <= 16'd0;
      num1_q   <= 16'd0;
      result_q <= 3'd0;
      err_q    <= 1'b0;
      resp0_q  <= 1'b0;
      resp1_q  <= 1'b0;
    end else begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            num0_q <= grant1 ? bus.req1_number0 : bus.req0_number0;
            num1_q <= grant1 ? bus.req1_number1 : bus.req0_number1;
            gnt_id <= grant1;
            ptr    <= grant0;      // next tie goes to the other requester
            cnt    <= 3'(CMP_LATENCY);
            state  <= WAIT;
          end
        end
        WAIT: begin
          // cnt hits 0 in the cycle the comparator output is settled.
          if (cnt == 3'd0) begin
            result_q <= bus.cmp_result;
            err_q    <= !is_legal(bus.cmp_result);
            resp0_q  <= !gnt_id;
            resp1_q  <= gnt_id;
            state    <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.cmp_number0 = num0_q;
  assign bus.cmp_number1 = num1_q;
  assign bus.resp_result = result_q;
  assign bus.resp_err    = err_q;
  // Reset suppresses a pulse that would otherwise land in the reset cycle.
  assign bus.resp0_valid = resp0_q && !reset;
  assign bus.resp1_valid = resp1_q && !reset;
  assign busy            = (state != IDLE) && !reset;
  assign state_dbg       = state;

endmodule
